mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-access stage of the 8-bit CPU, sitting between the execute stage and the 32×8 data memory array. It accepts one load/store-class request at a time over a valid/ready handshake and sequences the memory's combinational read port and single-cycle write enable. It returns the result over a second valid/ready handshake. It supports LOAD, STORE, SWAP and INC (read-modify-write), so the execute stage never touches memory timing directly.

## Interface
Parameters:
- ADDR_W, 5, memory address width (32 locations)
- DATA_W, 8, data width

Ports:
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clk
- Req_valid  in  1  request present
- Req_ready  out  1  unit can accept a request (high only in IDLE)
- Req_op  in  2  00 LOAD, 01 STORE, 10 SWAP, 11 INC
- Req_addr  in  ADDR_W  target location
- Req_data  in  DATA_W  write data for STORE/SWAP; ignored otherwise
- Resp_valid  out  1  result available; held until accepted
- Resp_ready  in  1  consumer accepts result
- Resp_data  out  DATA_W  result byte (see Operation)
- Resp_zero  out  1  Resp_data == 0
- Mem_Address  out  ADDR_W  to memory Address
- Mem_En  out  1  to memory write enable
- Mem_Data_wr  out  DATA_W  to memory Data_in
- Mem_Data_rd  in  DATA_W  from memory Data_out (combinational read of Mem_Address)

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE: Req_ready=1. On Req_valid&&Req_ready, latch op_q, addr_q=Req_addr and data_q=Req_data, then go to ACCESS.
- ACCESS: Mem_Address=addr_q. Capture Mem_Data_rd into rd_q.
  - LOAD: Resp_data := Mem_Data_rd; go to RESP.
  - STORE: Mem_En=1, Mem_Data_wr=data_q; Resp_data := data_q; go to RESP.
  - SWAP, INC: no write in this state; go to WRITE.
- WRITE: Mem_En=1, Mem_Address=addr_q.
  - SWAP: Mem_Data_wr=data_q; Resp_data := rd_q (old contents).
  - INC: Mem_Data_wr=rd_q+1 mod 256 (FF wraps to 00); Resp_data := new value.
  - Then go to RESP.
- RESP: Resp_valid=1, with Resp_data/Resp_zero stable. On Resp_ready, go to IDLE; otherwise hold.
- Mem_En is high only in ACCESS (STORE) and WRITE, and is gated by !Reset so no write occurs in a cycle where Reset=1.
- Mem_Address is registered (addr_q) and does not change outside IDLE. Mem_Data_wr is 00 when Mem_En=0.
- Req_op/Req_addr/Req_data are sampled only on the accept edge; later changes are ignored.

## Timing
- Reset values: state=IDLE, Req_ready=1, Resp_valid=0, Resp_data=00, Resp_zero=1, Mem_Address=0, Mem_En=0, Mem_Data_wr=00.
- Cycle 0 = accept cycle. ACCESS is cycle 1.
  - LOAD/STORE: Resp_valid from cycle 2.
  - SWAP/INC: WRITE in cycle 2, Resp_valid from cycle 3.
- The memory write commits on the rising edge ending the Mem_En cycle. A subsequent LOAD to the same address returns the new value.
- Earliest next accept is the cycle after the Resp handshake. Peak throughput is one op per 3 cycles (LOAD/STORE) or 4 cycles (SWAP/INC).
- Req_valid high while not in IDLE: no accept and no side effect. Requesters hold the request until Req_ready.
- Reset at any state, including mid-WRITE, returns to IDLE on that edge with no memory write. Any pending response is discarded.

## Structure
- Shared package cpu_mem_pkg:
  - op encodings (OP_LOAD, OP_STORE, OP_SWAP, OP_INC)
  - state encoding
  - ADDR_W/DATA_W defaults
- Single module. No sub-module is needed; the datapath (rd_q, incrementer, response register) is small enough to live with the FSM.

## Test plan
- After Reset, LOAD 0x1C -> Resp_data=AA, Resp_zero=0, Resp_valid in cycle 2. LOAD 0x1B -> FF.
- STORE 0x05 with data 3C, then LOAD 0x05 -> 3C. Mem_En high exactly one cycle with Mem_Address=05.
- SWAP 0x05 with data 7E (memory 3C) -> Resp_data=3C, Resp_valid in cycle 3. A following LOAD 0x05 -> 7E.
- INC 0x1B (FF) -> Resp_data=00, Resp_zero=1. LOAD 0x1B -> 00, confirming the wrap.
- Hold Resp_ready=0 for 5 cycles after a LOAD -> Resp_valid and Resp_data stay stable, Req_ready=0, and a second Req_valid is not accepted until after the handshake.
- Assert Reset during the WRITE cycle of INC 0x0A (value 10) -> Mem_En=0 in that cycle, IDLE next. A LOAD 0x0A after reset returns the memory's reset value 00.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-access stage: operation codes,
// FSM state encoding and default bus widths.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_SWAP  = 2'b10,
    OP_INC   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Memory-access stage: sequences LOAD/STORE/SWAP/INC against a 32x8 array
// with a combinational read port and a single-cycle write enable.
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req_valid,
  output logic              Req_ready,
  input  logic [1:0]        Req_op,
  input  logic [ADDR_W-1:0] Req_addr,
  input  logic [DATA_W-1:0] Req_data,
  output logic              Resp_valid,
  input  logic              Resp_ready,
  output logic [DATA_W-1:0] Resp_data,
  output logic              Resp_zero,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic              Mem_En,
  output logic [DATA_W-1:0] Mem_Data_wr,
  input  logic [DATA_W-1:0] Mem_Data_rd
);

  state_e            state, state_nxt;
  op_e               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] resp_q;
  logic              accept;

  function automatic logic [DATA_W-1:0] inc_wrap(input logic [DATA_W-1:0] v);
    return v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  assign accept = Req_valid && (state == ST_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = (op_q == OP_LOAD || op_q == OP_STORE) ? ST_RESP : ST_WRITE;
      ST_WRITE:  state_nxt = ST_RESP;
      ST_RESP:   if (Resp_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and response datapath; address/response are visible
  // outputs, so they get reset values, the internal operand registers do not.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q <= '0;
      resp_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= op_e'(Req_op);
            addr_q <= Req_addr;
            data_q <= Req_data;
          end
        end
        ST_ACCESS: begin
          rd_q <= Mem_Data_rd;
          if (op_q == OP_LOAD)       resp_q <= Mem_Data_rd;
          else if (op_q == OP_STORE) resp_q <= data_q;
        end
        ST_WRITE: begin
          resp_q <= (op_q == OP_SWAP) ? rd_q : inc_wrap(rd_q);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Req_ready   = (state == ST_IDLE);
    Resp_valid  = (state == ST_RESP);
    Resp_data   = resp_q;
    Resp_zero   = (resp_q == '0);
    Mem_Address = addr_q;
    Mem_En      = 1'b0;
    Mem_Data_wr = '0;
    if (!Reset) begin
      if (state == ST_ACCESS && op_q == OP_STORE) begin
        Mem_En      = 1'b1;
        Mem_Data_wr = data_q;
      end else if (state == ST_WRITE) begin
        Mem_En      = 1'b1;
        Mem_Data_wr = (op_q == OP_SWAP) ? data_q : inc_wrap(rd_q);
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed test-plan steps followed by random
// operations, compared against a plain array model of the memory.
module tb_mem_access_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Req_valid;
  logic       Req_ready;
  logic [1:0] Req_op;
  logic [4:0] Req_addr;
  logic [7:0] Req_data;
  logic       Resp_valid;
  logic       Resp_ready;
  logic [7:0] Resp_data;
  logic       Resp_zero;
  logic [4:0] Mem_Address;
  logic       Mem_En;
  logic [7:0] Mem_Data_wr;
  logic [7:0] Mem_Data_rd;

  logic [7:0] mem     [32];
  logic [7:0] ref_mem [32];

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 Clk = ~Clk;

  mem_access_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Req_valid   (Req_valid),
    .Req_ready   (Req_ready),
    .Req_op      (Req_op),
    .Req_addr    (Req_addr),
    .Req_data    (Req_data),
    .Resp_valid  (Resp_valid),
    .Resp_ready  (Resp_ready),
    .Resp_data   (Resp_data),
    .Resp_zero   (Resp_zero),
    .Mem_Address (Mem_Address),
    .Mem_En      (Mem_En),
    .Mem_Data_wr (Mem_Data_wr),
    .Mem_Data_rd (Mem_Data_rd)
  );

  // Data memory with a fixed reset image.
  assign Mem_Data_rd = mem[Mem_Address];
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[5'h1C] <= 8'hAA;
      mem[5'h1B] <= 8'hFF;
    end else if (Mem_En) begin
      mem[Mem_Address] <= Mem_Data_wr;
    end
  end

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    ref_mem[5'h1C] = 8'hAA;
    ref_mem[5'h1B] = 8'hFF;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction starting at a negedge in IDLE, ending at a negedge in IDLE.
  task automatic run_op(input logic [1:0] op, input logic [4:0] a, input logic [7:0] d,
                        input int hold);
    logic [7:0] exp, wr_exp;
    bit         rmw;
    exp    = 8'h00;
    wr_exp = 8'h00;
    rmw    = (op == 2'b10) || (op == 2'b11);
    case (op)
      2'b00: exp = ref_mem[a];
      2'b01: begin exp = d; wr_exp = d; ref_mem[a] = d; end
      2'b10: begin exp = ref_mem[a]; wr_exp = d; ref_mem[a] = d; end
      default: begin
        ref_mem[a] = 8'((int'(ref_mem[a]) + 1) % 256);
        exp = ref_mem[a];
        wr_exp = exp;
      end
    endcase

    chk("idle_req_ready", Req_ready, 1);
    Req_valid = 1'b1; Req_op = op; Req_addr = a; Req_data = d;
    @(negedge Clk);
    Req_valid = 1'b0;
    Req_op = 2'($urandom); Req_addr = 5'($urandom); Req_data = 8'($urandom);
    chk("access_resp_valid", Resp_valid, 0);
    chk("access_req_ready", Req_ready, 0);
    chk("access_addr", Mem_Address, a);
    chk("access_mem_en", Mem_En, op == 2'b01);
    chk("access_wr_data", Mem_Data_wr, (op == 2'b01) ? d : 8'h00);
    @(negedge Clk);
    if (rmw) begin
      chk("write_resp_valid", Resp_valid, 0);
      chk("write_mem_en", Mem_En, 1);
      chk("write_addr", Mem_Address, a);
      chk("write_wr_data", Mem_Data_wr, wr_exp);
      @(negedge Clk);
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_resp_valid", Resp_valid, 1);
      chk("hold_resp_data", Resp_data, exp);
      chk("hold_req_ready", Req_ready, 0);
      chk("hold_mem_en", Mem_En, 0);
      Req_valid = 1'b1; Req_op = 2'b01;
      Req_addr = 5'($urandom); Req_data = 8'($urandom);
      @(negedge Clk);
    end
    Req_valid  = 1'b0;
    Resp_ready = 1'b1;
    chk("resp_valid", Resp_valid, 1);
    chk("resp_data", Resp_data, exp);
    chk("resp_zero", Resp_zero, exp == 8'h00);
    chk("resp_addr", Mem_Address, a);
    chk("resp_mem_en", Mem_En, 0);
    chk("resp_wr_data", Mem_Data_wr, 0);
    @(negedge Clk);
    Resp_ready = 1'b0;
    chk("post_resp_valid", Resp_valid, 0);
    chk("post_req_ready", Req_ready, 1);
  endtask

  initial begin
    Reset = 1'b1; Req_valid = 1'b0; Req_op = 2'b00; Req_addr = '0; Req_data = '0;
    Resp_ready = 1'b0;
    ref_reset();
    repeat (2) @(negedge Clk);
    chk("rst_req_ready", Req_ready, 1);
    chk("rst_resp_valid", Resp_valid, 0);
    chk("rst_resp_data", Resp_data, 0);
    chk("rst_resp_zero", Resp_zero, 1);
    chk("rst_mem_addr", Mem_Address, 0);
    chk("rst_mem_en", Mem_En, 0);
    chk("rst_wr_data", Mem_Data_wr, 0);
    Reset = 1'b0;
    @(negedge Clk);

    run_op(2'b00, 5'h1C, 8'h00, 0);
    run_op(2'b00, 5'h1B, 8'h00, 0);
    run_op(2'b01, 5'h05, 8'h3C, 0);
    run_op(2'b00, 5'h05, 8'h00, 0);
    run_op(2'b10, 5'h05, 8'h7E, 0);
    run_op(2'b00, 5'h05, 8'h00, 0);
    run_op(2'b11, 5'h1B, 8'h00, 0);
    run_op(2'b00, 5'h1B, 8'h00, 0);
    run_op(2'b00, 5'h1C, 8'h00, 5);

    // Reset landing in the WRITE cycle of an INC.
    run_op(2'b01, 5'h0A, 8'h10, 0);
    Req_valid = 1'b1; Req_op = 2'b11; Req_addr = 5'h0A; Req_data = 8'h00;
    @(negedge Clk);
    Req_valid = 1'b0;
    @(negedge Clk);
    chk("rmw_write_en_pre", Mem_En, 1);
    Reset = 1'b1;
    #1;
    chk("rmw_reset_mem_en", Mem_En, 0);
    chk("rmw_reset_wr_data", Mem_Data_wr, 0);
    @(negedge Clk);
    chk("rmw_reset_req_ready", Req_ready, 1);
    chk("rmw_reset_resp_valid", Resp_valid, 0);
    chk("rmw_reset_resp_data", Resp_data, 0);
    chk("rmw_reset_addr", Mem_Address, 0);
    Reset = 1'b0;
    ref_reset();
    @(negedge Clk);
    run_op(2'b00, 5'h0A, 8'h00, 0);

    for (int k = 0; k < 80; k++) begin
      run_op(2'($urandom), 5'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end
    for (int a = 0; a < 32; a++) run_op(2'b00, 5'(a), 8'h00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
